// File: rtl/text_pkg.sv
// Shared definitions for the character-grid text renderer.
//   CHAR_W      : width of a character code held in the buffer
//   GLYPH_ROWS  : scanlines per character cell (font glyph height)
//   GLYPH_COLS  : pixels per character cell (font glyph width)
//   ROM_AW      : font ROM address width, {char, glyph_row}
//   state_t     : controller FSM states
package text_pkg;

  localparam int CHAR_W     = 7;
  localparam int GLYPH_ROWS = 16;
  localparam int GLYPH_COLS = 8;
  localparam int ROM_AW     = 11;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/text_char_buf.sv
// Character buffer: CELLS x CHAR_W register file.
// One combinational read port (display side) and one synchronous write
// port (host writes and bulk clear). Contents are not reset.
//   clk   : system clock
//   we    : write enable, sampled on the rising edge
//   waddr : write cell index
//   wdata : character code to store
//   raddr : read cell index
//   rdata : character code at raddr, same cycle
module text_char_buf
  import text_pkg::*;
#(
  parameter int CELLS = 64,
  parameter int IDX_W = $clog2(CELLS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [CHAR_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [CHAR_W-1:0] rdata
);

  // Addresses at or past CELLS are possible when CELLS is not a power of
  // two; such writes are dropped and such reads return 0.
  localparam logic [IDX_W:0] CELLS_L = (IDX_W+1)'(CELLS);

  logic [CHAR_W-1:0] mem [CELLS];

  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < CELLS_L)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = ({1'b0, raddr} < CELLS_L) ? mem[raddr] : '0;

endmodule

// File: rtl/text_tile_ctrl.sv
// Character-grid text renderer controller.
// Maps the raster position onto a COLS x ROWS grid of 8x16 cells, looks the
// cell's character up in the character buffer, drives the external font ROM
// and turns the returned glyph row into a pixel colour with a fixed 3-cycle
// latency. The host writes cells through a valid/ready port; a bulk clear
// fills every cell with CLR_CHAR, one cell per cycle.
//   clk, reset_n      : clock, synchronous active-low reset
//   PIXEL_H, PIXEL_V  : current raster column / line
//   PIXEL             : rendered colour, 3 cycles after PIXEL_H/PIXEL_V
//   rom_addr          : registered font ROM address {char, glyph_row}
//   rom_data          : font ROM data, valid 1 cycle after rom_addr
//   wr_valid/wr_ready : host write handshake
//   wr_col, wr_row    : host write target cell
//   wr_char           : host write character code
//   clear_req         : pulse to start a bulk clear
//   busy              : bulk clear in progress
module text_tile_ctrl
  import text_pkg::*;
#(
  parameter int              COLS     = 16,
  parameter int              ROWS     = 4,
  parameter int              H_START  = 0,
  parameter int              V_START  = 0,
  parameter logic [2:0]      FG       = 3'b111,
  parameter logic [2:0]      BG       = 3'b000,
  parameter logic [6:0]      CLR_CHAR = 7'h20
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [10:0]              PIXEL_H,
  input  logic [10:0]              PIXEL_V,
  output logic [2:0]               PIXEL,
  output logic [ROM_AW-1:0]        rom_addr,
  input  logic [7:0]               rom_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [$clog2(COLS)-1:0]  wr_col,
  input  logic [$clog2(ROWS)-1:0]  wr_row,
  input  logic [CHAR_W-1:0]        wr_char,
  input  logic                     clear_req,
  output logic                     busy
);

  localparam int CELLS  = COLS * ROWS;
  localparam int IDX_W  = $clog2(CELLS);
  localparam int GRID_W = GLYPH_COLS * COLS;
  localparam int GRID_H = GLYPH_ROWS * ROWS;

  // Controller state
  state_t            state, state_nx;
  logic [IDX_W-1:0]  clr_idx;

  // Buffer write port
  logic              cbuf_we;
  logic [IDX_W-1:0]  cbuf_waddr;
  logic [CHAR_W-1:0] cbuf_wdata;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_in_range;

  // Display pipeline
  logic [10:0]       rel_h_p0, rel_v_p0;
  logic              in_win_p0;
  logic [IDX_W-1:0]  cell_p0;
  logic [CHAR_W-1:0] char_p0;
  logic [3:0]        grow_p0;
  logic [2:0]        pix_bit_p0;
  logic              vld_p1, vld_p2;
  logic [2:0]        pix_bit_p1, pix_bit_p2;

  // ---------------------------------------------------------------
  // Stage 0: window test, cell index, combinational buffer read
  // ---------------------------------------------------------------
  assign rel_h_p0   = PIXEL_H - 11'(H_START);
  assign rel_v_p0   = PIXEL_V - 11'(V_START);
  assign in_win_p0  = (32'(PIXEL_H) >= H_START) && (32'(rel_h_p0) < GRID_W) &&
                      (32'(PIXEL_V) >= V_START) && (32'(rel_v_p0) < GRID_H);
  assign cell_p0    = in_win_p0 ?
                      IDX_W'(32'(rel_v_p0[10:4]) * COLS + 32'(rel_h_p0[10:3])) : '0;
  assign grow_p0    = rel_v_p0[3:0];
  assign pix_bit_p0 = rel_h_p0[2:0];

  text_char_buf #(
    .CELLS (CELLS),
    .IDX_W (IDX_W)
  ) u_char_buf (
    .clk   (clk),
    .we    (cbuf_we),
    .waddr (cbuf_waddr),
    .wdata (cbuf_wdata),
    .raddr (cell_p0),
    .rdata (char_p0)
  );

  // ---------------------------------------------------------------
  // Stage 1: font ROM address registered
  // Stage 2: font ROM data arrives
  // Stage 3: pixel colour registered
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rom_addr <= '0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      PIXEL    <= BG;
    end else begin
      rom_addr <= in_win_p0 ? {char_p0, grow_p0} : '0;
      vld_p1   <= in_win_p0;
      vld_p2   <= vld_p1;
      PIXEL    <= (vld_p2 && rom_data[3'd7 - pix_bit_p2]) ? FG : BG;
    end
  end

  always_ff @(posedge clk) begin
    pix_bit_p1 <= pix_bit_p0;
    pix_bit_p2 <= pix_bit_p1;
  end

  // ---------------------------------------------------------------
  // Host write / bulk clear arbitration
  // ---------------------------------------------------------------
  assign wr_idx      = IDX_W'(32'(wr_row) * COLS + 32'(wr_col));
  assign wr_in_range = (32'(wr_col) < COLS) && (32'(wr_row) < ROWS);

  always_comb begin
    state_nx   = state;
    wr_ready   = 1'b0;
    cbuf_we    = 1'b0;
    cbuf_waddr = '0;
    cbuf_wdata = '0;
    case (state)
      IDLE: begin
        wr_ready = 1'b1;
        // Out-of-range targets are accepted but never reach the buffer.
        if (wr_valid && wr_in_range) begin
          cbuf_we    = 1'b1;
          cbuf_waddr = wr_idx;
          cbuf_wdata = wr_char;
        end
        if (clear_req) begin
          state_nx = CLEAR;
        end
      end
      CLEAR: begin
        cbuf_we    = 1'b1;
        cbuf_waddr = clr_idx;
        cbuf_wdata = CLR_CHAR;
        if (clr_idx == IDX_W'(CELLS - 1)) begin
          state_nx = IDLE;
        end
      end
    endcase
    // A reset edge aborts the clear without writing the current cell.
    if (!reset_n) begin
      cbuf_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      clr_idx <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        clr_idx <= '0;
      end else begin
        clr_idx <= clr_idx + 1'b1;
      end
    end
  end

  assign busy = (state == CLEAR);

endmodule

// File: tb/tb_text_tile_ctrl.sv
// Self-checking bench for text_tile_ctrl (default parameters: 16x4 grid).
module tb_text_tile_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] PIXEL_H, PIXEL_V;
  logic [2:0]  PIXEL;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        wr_valid, wr_ready;
  logic [3:0]  wr_col;
  logic [1:0]  wr_row;
  logic [6:0]  wr_char;
  logic        clear_req, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  text_tile_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .PIXEL_H   (PIXEL_H),
    .PIXEL_V   (PIXEL_V),
    .PIXEL     (PIXEL),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_col    (wr_col),
    .wr_row    (wr_row),
    .wr_char   (wr_char),
    .clear_req (clear_req),
    .busy      (busy)
  );

  // Font ROM model: 'A' row 0 is 8'h18, every other entry a fixed pattern.
  function automatic logic [7:0] font(input logic [10:0] a);
    if (a == 11'h410) return 8'h18;
    return a[7:0] ^ 8'hA5;
  endfunction

  always @(posedge clk) rom_data <= font(rom_addr);

  // Reference character buffer, indexed row*16+col.
  logic [6:0] bufm [64];

  function automatic logic [10:0] m_addr(input int h, input int v);
    if (h < 128 && v < 64) return {bufm[(v / 16) * 16 + h / 8], 4'(v % 16)};
    return 11'd0;
  endfunction

  function automatic logic [2:0] m_pix(input int h, input int v);
    logic [7:0] b;
    if (!(h < 128 && v < 64)) return 3'b000;
    b = font(m_addr(h, v));
    return b[7 - (h % 8)] ? 3'b111 : 3'b000;
  endfunction

  typedef struct {
    logic [10:0] h, v;
    logic        wv;
    logic [3:0]  wc;
    logic [1:0]  wr;
    logic [6:0]  wch;
    logic [10:0] ea;
    logic [2:0]  ep;
  } pt_t;

  pt_t q[$];

  typedef struct {
    logic [10:0] h, v, addr;
    logic [2:0]  pix;
  } vec_t;

  vec_t tbl[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Queue one raster point (with an optional host write in the same cycle).
  // Expected outputs use the buffer as it stands before this cycle's write.
  task automatic push_pt(input int h, input int v, input bit wv, input int wc,
                         input int wr, input int wch);
    pt_t p;
    p.h = 11'(h); p.v = 11'(v); p.wv = wv;
    p.wc = 4'(wc); p.wr = 2'(wr); p.wch = 7'(wch);
    p.ea = m_addr(h, v);
    p.ep = m_pix(h, v);
    if (wv) bufm[wr * 16 + wc] = 7'(wch);
    q.push_back(p);
  endtask

  // One point per cycle; rom_addr checked 1 cycle and PIXEL 3 cycles later.
  task automatic drive_points();
    int n;
    n = q.size();
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) begin
        PIXEL_H = q[i].h;  PIXEL_V = q[i].v;
        wr_valid = q[i].wv; wr_col = q[i].wc; wr_row = q[i].wr; wr_char = q[i].wch;
      end else begin
        PIXEL_H = 11'd2000; PIXEL_V = 11'd2000; wr_valid = 1'b0;
      end
      step();
      if (i < n) chk("rom_addr", 32'(rom_addr), 32'(q[i].ea));
      if (i >= 2) chk("pixel", 32'(PIXEL), 32'(q[i - 2].ep));
    end
    wr_valid = 1'b0;
    q.delete();
  endtask

  task automatic check_cells();
    for (int c = 0; c < 64; c++) push_pt((c % 16) * 8, (c / 16) * 16, 1'b0, 0, 0, 0);
    drive_points();
  endtask

  initial begin
    int n;
    reset_n = 1'b0; PIXEL_H = 11'd2000; PIXEL_V = 11'd2000;
    wr_valid = 1'b0; wr_col = '0; wr_row = '0; wr_char = '0; clear_req = 1'b0;
    repeat (3) step();
    chk("reset_pixel", 32'(PIXEL), 32'h0);
    chk("reset_rom_addr", 32'(rom_addr), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;
    step();
    chk("idle_wr_ready", 32'(wr_ready), 32'h1);

    // Bulk clear with host writes hammering throughout
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    wr_valid = 1'b1; wr_col = 4'd0; wr_row = 2'd0; wr_char = 7'h7F;
    n = 0;
    while (busy && n < 200) begin
      chk("wr_ready_in_clear", 32'(wr_ready), 32'h0);
      n++;
      step();
    end
    wr_valid = 1'b0;
    chk("clear_busy_cycles", 32'(n), 32'd64);
    for (int i = 0; i < 64; i++) bufm[i] = 7'h20;
    check_cells();

    // Host writes: cell 0 = 'A', cell (col 2,row 1) = 0x50
    push_pt(2000, 2000, 1'b1, 0, 0, 7'h41);
    push_pt(2000, 2000, 1'b1, 2, 1, 7'h50);
    drive_points();

    // Directed vectors
    tbl[0]  = '{11'd0,   11'd0,  11'h410, 3'd0};
    tbl[1]  = '{11'd1,   11'd0,  11'h410, 3'd0};
    tbl[2]  = '{11'd2,   11'd0,  11'h410, 3'd0};
    tbl[3]  = '{11'd3,   11'd0,  11'h410, 3'd7};
    tbl[4]  = '{11'd4,   11'd0,  11'h410, 3'd7};
    tbl[5]  = '{11'd5,   11'd0,  11'h410, 3'd0};
    tbl[6]  = '{11'd6,   11'd0,  11'h410, 3'd0};
    tbl[7]  = '{11'd7,   11'd0,  11'h410, 3'd0};
    tbl[8]  = '{11'd16,  11'd16, 11'h500, 3'd7};
    tbl[9]  = '{11'd17,  11'd16, 11'h500, 3'd0};
    tbl[10] = '{11'd18,  11'd17, 11'h501, 3'd7};
    tbl[11] = '{11'd23,  11'd31, 11'h50F, 3'd0};
    tbl[12] = '{11'd128, 11'd0,  11'h000, 3'd0};
    tbl[13] = '{11'd0,   11'd64, 11'h000, 3'd0};
    tbl[14] = '{11'd127, 11'd63, 11'h20F, 3'd0};
    tbl[15] = '{11'd120, 11'd62, 11'h20E, 3'd7};
    for (int i = 0; i < 16; i++) begin
      pt_t p;
      p.h = tbl[i].h; p.v = tbl[i].v; p.wv = 1'b0; p.wc = '0; p.wr = '0; p.wch = '0;
      p.ea = tbl[i].addr; p.ep = tbl[i].pix;
      q.push_back(p);
    end
    drive_points();

    // Random raster with interleaved host writes
    for (int i = 0; i < 300; i++) begin
      push_pt($urandom_range(0, 150), $urandom_range(0, 80), ($urandom_range(0, 2) == 0),
              $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 127));
    end
    drive_points();

    // Write and clear in the same cycle; second clear_req mid-clear
    wr_valid = 1'b1; wr_col = 4'd5; wr_row = 2'd0; wr_char = 7'h41; clear_req = 1'b1;
    chk("same_cycle_wr_ready", 32'(wr_ready), 32'h1);
    step();
    wr_valid = 1'b0; clear_req = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      PIXEL_H = (n == 0) ? 11'd40 : 11'd2000;
      PIXEL_V = (n == 0) ? 11'd0 : 11'd2000;
      clear_req = (n == 20);
      n++;
      step();
      if (n == 1) chk("write_before_clear", 32'(rom_addr), 32'h410);
    end
    clear_req = 1'b0; PIXEL_H = 11'd2000; PIXEL_V = 11'd2000;
    chk("clear2_busy_cycles", 32'(n), 32'd64);
    for (int i = 0; i < 64; i++) bufm[i] = 7'h20;
    check_cells();

    // Reset in the middle of a clear
    for (int c = 0; c < 64; c++) push_pt(2000, 2000, 1'b1, c % 16, c / 16, 7'h30 + c);
    drive_points();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (10) step();
    chk("busy_before_abort", 32'(busy), 32'h1);
    reset_n = 1'b0;
    step();
    chk("busy_after_abort", 32'(busy), 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) bufm[i] = 7'h20;
    check_cells();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
